// File: rtl/bjk_rom_loader.sv
// rtl/bjk_rom_loader.sv - HPS download to Bomb Jack ROM write-port loader; optional checksum gate via ROM_CKSUM_CHECK_EN
module bjk_rom_loader #(
    parameter logic [7:0]  ROM_INDEX    = 8'd0,
    parameter logic [16:0] SND_BASE     = 17'h0A000,
    parameter logic [16:0] GFX_BASE     = 17'h0C000,
    parameter logic [16:0] MAP_BASE     = 17'h1C000,
    parameter logic [16:0] END_ADDR     = 17'h1D000,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_we_cpu,
    output logic        rom_we_snd,
    output logic        rom_we_gfx,
    output logic        rom_we_map,
    output logic [17:0] byte_count,
    output logic        loading,
    output logic        load_done,
    output logic        load_err,
    output logic        core_reset
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

    state_t      state;
    logic        qdl;
    logic        qdl_q;
    logic        qdl_rise;
    logic        qdl_fall;
    logic        start;
    logic        in_range;
    logic        seq_err;
    logic        sum_ok;
    logic [16:0] addr17;

    assign qdl      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign qdl_rise = qdl && !qdl_q;
    assign qdl_fall = !qdl && qdl_q;
    assign start    = qdl_rise && (state == IDLE || state == DONE || state == ERR);
    assign in_range = ioctl_addr < {8'd0, END_ADDR};
    assign addr17   = ioctl_addr[16:0];

`ifdef ROM_CKSUM_CHECK_EN
    logic [15:0] sum;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (start) begin
            sum <= '0;
        end else if (state == LOAD && ioctl_wr && in_range) begin
            sum <= sum + {8'd0, ioctl_dout};
        end
    end

    assign sum_ok = (sum == EXPECTED_SUM);
`else
    logic unused_expected_sum;
    assign unused_expected_sum = ^EXPECTED_SUM;
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            qdl_q      <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= '0;
            rom_we_cpu <= 1'b0;
            rom_we_snd <= 1'b0;
            rom_we_gfx <= 1'b0;
            rom_we_map <= 1'b0;
            byte_count <= '0;
            seq_err    <= 1'b0;
            loading    <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            qdl_q      <= qdl;
            rom_we_cpu <= 1'b0;
            rom_we_snd <= 1'b0;
            rom_we_gfx <= 1'b0;
            rom_we_map <= 1'b0;
            load_done  <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (qdl_rise) begin
                        state      <= LOAD;
                        loading    <= 1'b1;
                        byte_count <= '0;
                        seq_err    <= 1'b0;
                        load_err   <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                LOAD: begin
                    // A write landing with the closing edge is still taken; its strobe falls in CHECK.
                    if (ioctl_wr) begin
                        if (in_range) begin
                            if (ioctl_addr != {7'd0, byte_count}) seq_err <= 1'b1;
                            if (byte_count != '1) byte_count <= byte_count + 18'd1;
                            rom_data <= ioctl_dout;
                            if (addr17 < SND_BASE) begin
                                rom_we_cpu <= 1'b1;
                                rom_addr   <= addr17;
                            end else if (addr17 < GFX_BASE) begin
                                rom_we_snd <= 1'b1;
                                rom_addr   <= addr17 - SND_BASE;
                            end else if (addr17 < MAP_BASE) begin
                                rom_we_gfx <= 1'b1;
                                rom_addr   <= addr17 - GFX_BASE;
                            end else begin
                                rom_we_map <= 1'b1;
                                rom_addr   <= addr17 - MAP_BASE;
                            end
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    if (qdl_fall) begin
                        state   <= CHECK;
                        loading <= 1'b0;
                    end
                end
                CHECK: begin
                    if (byte_count == {1'b0, END_ADDR} && !seq_err && sum_ok) begin
                        state      <= DONE;
                        load_done  <= 1'b1;
                        core_reset <= 1'b0;
                    end else begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bjk_rom_loader.sv
// tb/tb_bjk_rom_loader.sv - vector table and strobe scoreboard bench for bjk_rom_loader (scaled memory map)
module tb_bjk_rom_loader;
    localparam logic [16:0] SND  = 17'h00A00;
    localparam logic [16:0] GFX  = 17'h00C00;
    localparam logic [16:0] MAP  = 17'h01C00;
    localparam logic [16:0] ENDA = 17'h01D00;
    // Byte sum of data=addr[7:0] over 0x1D00 bytes: 29 * 0x7F80 mod 2^16.
    localparam logic [15:0] GOOD_SUM = 16'h7180;
`ifdef ROM_CKSUM_CHECK_EN
    localparam bit CKSUM_ON = 1'b1;
`else
    localparam bit CKSUM_ON = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_we_cpu, rom_we_snd, rom_we_gfx, rom_we_map;
    logic [17:0] byte_count;
    logic        loading, load_done, load_err, core_reset;

    always #5 clk_sys = ~clk_sys;

    bjk_rom_loader #(
        .ROM_INDEX(8'd0), .SND_BASE(SND), .GFX_BASE(GFX), .MAP_BASE(MAP),
        .END_ADDR(ENDA), .EXPECTED_SUM(GOOD_SUM)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_we_cpu(rom_we_cpu), .rom_we_snd(rom_we_snd), .rom_we_gfx(rom_we_gfx),
        .rom_we_map(rom_we_map), .byte_count(byte_count), .loading(loading),
        .load_done(load_done), .load_err(load_err), .core_reset(core_reset)
    );

    typedef struct { int due; logic [3:0] we; logic [16:0] a; logic [7:0] d; } exp_t;
    typedef struct { logic [24:0] addr; logic [7:0] data; logic [3:0] we; logic [16:0] ra; } vec_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    vec_t       vt[10];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_pulses = 0;
    int         n_in;
    int         cnt[4];
    bit         sb_en = 1'b0;
    bit         dl_rom = 1'b0;
    logic [3:0] we_v;

    assign we_v = {rom_we_map, rom_we_gfx, rom_we_snd, rom_we_cpu};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [16:0] a, input logic [7:0] d, input int due);
        exp_t e;
        e.due = due;
        e.d   = d;
        if (a < SND)      begin e.we = 4'b0001; e.a = a;       end
        else if (a < GFX) begin e.we = 4'b0010; e.a = a - SND; end
        else if (a < MAP) begin e.we = 4'b0100; e.a = a - GFX; end
        else              begin e.we = 4'b1000; e.a = a - MAP; end
        return e;
    endfunction

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (load_done) done_pulses++;
        if (sb_en) begin
            if (we_v != 4'b0) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_strobe", we_v, 4'b0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_we", we_v, mon_e.we);
                    check("sb_rom_addr", rom_addr, mon_e.a);
                    check("sb_rom_data", rom_data, mon_e.d);
                    check("sb_latency", cyc, mon_e.due);
                    for (int r = 0; r < 4; r++) if (we_v[r]) cnt[r]++;
                end
            end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
                check("sb_missing_strobe", we_v, sbq[0].we);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic open_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        dl_rom = (idx == 8'd0);
        done_pulses = 0;
        @(negedge clk_sys);
    endtask

    task automatic close_dl();
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit last);
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        if (last) ioctl_download = 1'b0;
        if (sb_en && dl_rom && a < {8'd0, ENDA}) sbq.push_back(model(a[16:0], d, cyc + 1));
    endtask

    // skip >= 0 withholds that address and sends it as the final byte instead.
    task automatic run_load(input int n, input bit zero, input int skip);
        int a;
        open_dl(8'd0);
        check("loading_after_open", loading, 1'b1);
        check("core_reset_in_load", core_reset, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (skip < 0 || i < skip) a = i;
            else if (i < n - 1)       a = i + 1;
            else                      a = skip;
            wr(a[24:0], zero ? 8'h00 : a[7:0], i == n - 1);
        end
        idle();
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic expect_end(input string tag, input bit ok, input int count);
        check({tag, "_done_pulses"}, done_pulses, ok ? 1 : 0);
        check({tag, "_load_err"}, load_err, !ok);
        check({tag, "_core_reset"}, core_reset, !ok);
        check({tag, "_byte_count"}, byte_count, count);
        check({tag, "_loading"}, loading, 1'b0);
        check({tag, "_sb_pending"}, sbq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{25'h0000000, 8'h11, 4'b0001, 17'h00000};
        vt[1] = '{25'h00009FF, 8'h22, 4'b0001, 17'h009FF};
        vt[2] = '{25'h0000A00, 8'h33, 4'b0010, 17'h00000};
        vt[3] = '{25'h0000BFF, 8'h44, 4'b0010, 17'h001FF};
        vt[4] = '{25'h0000C00, 8'h55, 4'b0100, 17'h00000};
        vt[5] = '{25'h0001BFF, 8'h66, 4'b0100, 17'h00FFF};
        vt[6] = '{25'h0001C00, 8'h77, 4'b1000, 17'h00000};
        vt[7] = '{25'h0001CFF, 8'h88, 4'b1000, 17'h000FF};
        vt[8] = '{25'h0001D00, 8'h99, 4'b0000, 17'h00000};
        vt[9] = '{25'h1FFFFFF, 8'hAA, 4'b0000, 17'h00000};

        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_we", we_v, 4'b0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_data", rom_data, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_loading", loading, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_load_err", load_err, 1'b0);
        check("rst_core_reset", core_reset, 1'b1);
        reset_n = 1'b1;

        sb_en = 1'b1;
        for (int r = 0; r < 4; r++) cnt[r] = 0;
        run_load(ENDA, 1'b0, -1);
        expect_end("full", 1'b1, ENDA);
        check("full_cnt_cpu", cnt[0], SND);
        check("full_cnt_snd", cnt[1], GFX - SND);
        check("full_cnt_gfx", cnt[2], MAP - GFX);
        check("full_cnt_map", cnt[3], ENDA - MAP);

        open_dl(8'd1);
        for (int i = 0; i < 16; i++) wr(i, 8'hA5, 1'b0);
        idle();
        close_dl();
        repeat (3) @(negedge clk_sys);
        check("idx1_core_reset", core_reset, 1'b0);
        check("idx1_byte_count", byte_count, ENDA);
        check("idx1_loading", loading, 1'b0);
        check("idx1_done_pulses", done_pulses, 0);
        check("idx1_load_err", load_err, 1'b0);

        sb_en = 1'b0;
        open_dl(8'd0);
        check("vec_core_reset_reentry", core_reset, 1'b1);
        n_in = 0;
        for (int i = 0; i < 10; i++) begin
            wr(vt[i].addr, vt[i].data, 1'b0);
            idle();
            check("vec_we", we_v, vt[i].we);
            if (vt[i].we != 4'b0) begin
                check("vec_rom_addr", rom_addr, vt[i].ra);
                check("vec_rom_data", rom_data, vt[i].data);
                n_in++;
            end
            check("vec_byte_count", byte_count, n_in);
        end
        close_dl();
        repeat (3) @(negedge clk_sys);
        expect_end("vec", 1'b0, n_in);

        sb_en = 1'b1;
        run_load(ENDA - 1, 1'b0, -1);
        expect_end("trunc", 1'b0, ENDA - 1);

        run_load(ENDA, 1'b0, 'h100);
        expect_end("skip", 1'b0, ENDA);

        open_dl(8'd0);
        for (int i = 0; i < 'h500; i++) wr(i, i[7:0], 1'b0);
        idle();
        check("rst_mid_loading_before", loading, 1'b1);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_core_reset", core_reset, 1'b1);
        check("rst_mid_loading", loading, 1'b0);
        check("rst_mid_byte_count", byte_count, 0);
        check("rst_mid_we", we_v, 4'b0);
        check("rst_mid_sb_pending", sbq.size(), 0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        reset_n = 1'b1;
        run_load(ENDA, 1'b0, -1);
        expect_end("after_reset", 1'b1, ENDA);

        run_load(ENDA, 1'b1, -1);
        expect_end("cksum", !CKSUM_ON, ENDA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bjk_rom_loader.md
Name: bjk_rom_loader

Overview:
- Sits between the HPS download stream and bombjack_top's ROM write port.
- Decodes the linear download into four ROM regions (main CPU, sound CPU, graphics, background map), registers the write, and issues a per-region write strobe with a region-local address.
- Tracks byte count and sequence integrity, then reports load completion or failure.
- Holds the core in reset until a good image has been loaded.

Parameters:
- ROM_INDEX, 8'd0, ioctl_index value that selects a ROM download.
- SND_BASE, 17'h0A000, first byte of the sound-CPU region (main CPU region starts at 0).
- GFX_BASE, 17'h0C000, first byte of the graphics region.
- MAP_BASE, 17'h1C000, first byte of the background-map region.
- END_ADDR, 17'h1D000, total image length in bytes; first address past the map region.
- EXPECTED_SUM, 16'h0000, expected 16-bit byte sum of the image; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download type.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- rom_addr  out  17  region-local byte address (ioctl_addr minus region base).
- rom_data  out  8  registered byte.
- rom_we_cpu  out  1  write strobe, main CPU region.
- rom_we_snd  out  1  write strobe, sound CPU region.
- rom_we_gfx  out  1  write strobe, graphics region.
- rom_we_map  out  1  write strobe, background-map region.
- byte_count  out  18  bytes accepted in the current load.
- loading  out  1  high in LOAD state.
- load_done  out  1  one-cycle pulse on successful completion.
- load_err  out  1  sticky failure flag, cleared at the start of the next load.
- core_reset  out  1  active-high reset for bombjack_top; high unless state is DONE.

Behaviour:
- Reset values: all outputs 0 except core_reset=1. State IDLE.
- Qualified download (qdl) = ioctl_download && ioctl_index==ROM_INDEX. Edge detection uses qdl registered once.
- FSM states: IDLE, LOAD, CHECK, DONE, ERR.
  - IDLE/DONE/ERR → LOAD on qdl rising edge. Entry clears byte_count, the sum accumulator, the seq_err flag and load_err.
  - LOAD → CHECK on qdl falling edge.
  - CHECK is exactly one cycle. It goes to DONE if byte_count==END_ADDR and seq_err==0; otherwise it goes to ERR.
  - Entering DONE asserts load_done for one cycle. Entering ERR sets load_err.
- Downloads with another ioctl_index leave state and outputs untouched. core_reset stays at its current value.
- Write path, in LOAD only, on ioctl_wr:
  - Address in range (ioctl_addr < END_ADDR):
    - If ioctl_addr != byte_count, set seq_err. The byte is still written.
    - Increment byte_count and add the byte, zero-extended, to a 16-bit wrapping sum.
    - One cycle later, drive rom_addr, rom_data and exactly one rom_we_* high for one cycle.
  - Address out of range (ioctl_addr >= END_ADDR): set seq_err, emit no strobe, leave byte_count unchanged.
- Region select, using strict less-than on the upper bound:
  - cpu: addr < SND_BASE.
  - snd: SND_BASE <= addr < GFX_BASE.
  - gfx: GFX_BASE <= addr < MAP_BASE.
  - map: MAP_BASE <= addr < END_ADDR.
- Latency: ioctl_wr to rom_we_* is exactly 1 clk_sys cycle. Back-to-back ioctl_wr on consecutive cycles is supported without loss.
- Falling edge of qdl in the same cycle as a final ioctl_wr: the byte is counted and the strobe is still emitted in the CHECK cycle. CHECK evaluates the updated byte_count.
- byte_count saturates at 2^18-1.
- reset_n low at any time, including mid-LOAD: immediate return to IDLE, strobes deasserted, core_reset=1. A partial image is never reported done.

Optional Feature:
- Macro ROM_CKSUM_CHECK_EN.
- Defined: CHECK additionally requires sum==EXPECTED_SUM; a mismatch goes to ERR.
- Undefined: the sum accumulator is not built and EXPECTED_SUM is ignored.

Test Plan:
- Contiguous load of bytes 0..0x1CFFF, data=addr[7:0], index 0:
  - 0x1D000 total strobes: 0xA000 cpu, 0x2000 snd, 0x10000 gfx, 0x1000 map.
  - load_done pulses once, load_err=0, core_reset falls.
- Boundary write at addr 0x09FFF then 0x0A000:
  - rom_we_cpu with rom_addr 0x09FFF, then rom_we_snd with rom_addr 0x00000.
  - Each strobe appears exactly 1 cycle after its ioctl_wr.
- Truncated load stopping at 0x1CFFE bytes: ERR, load_err=1, core_reset stays 1, no load_done.
- Skipped address (0x100 omitted, 0x101 sent): seq_err, so ERR after the window closes; the 0x101 byte is still strobed.
- reset_n pulsed low mid-LOAD at byte 0x5000: core_reset=1 and state IDLE within the same cycle. A fresh full load then succeeds.
- Download with index 1 after DONE: no strobes, core_reset stays 0. With ROM_CKSUM_CHECK_EN and a wrong EXPECTED_SUM, a full load ends in ERR.
